// File: rtl/arith_pkg.sv
// Shared constants for the arithmetic unit (multiplier and divider).
package arith_pkg;

  // Operand width shared by the multiplier and the divider.
  localparam int DIV_WIDTH = 16;

  // Divider FSM state encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/div_sub_row.sv
// Combinational ripple subtractor built from full-adder cells.
// It computes diff = a - b as a + ~b + 1. borrow is the inverted final carry,
// so borrow is high exactly when a < b.
module div_sub_row #(
  parameter int W = 17
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow
);

  logic [W:0]   carry;
  logic [W-1:0] b_inv;

  assign b_inv    = ~b;
  // The +1 of the two's-complement negation enters as the initial carry.
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign diff[i]    = a[i] ^ b_inv[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b_inv[i]) | (carry[i] & (a[i] ^ b_inv[i]));
  end

  assign borrow = ~carry[W];

endmodule

// File: rtl/seq_divider16.sv
// Sequential unsigned radix-2 restoring divider, one quotient bit per clock.
// Uses a start/busy/done handshake. Results and div_by_zero are held until the
// next division completes.
module seq_divider16
  import arith_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] r_reg;    // partial remainder
  logic [WIDTH-1:0] q_reg;    // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] div_reg;  // divisor latched on the accepting edge

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic             sub_ok;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;

  // The trial value is the remainder shifted left by one, with the next dividend bit appended.
  assign trial = {r_reg, q_reg[WIDTH-1]};

  div_sub_row #(.W(WIDTH + 1)) u_sub (
    .a      (trial),
    .b      ({1'b0, div_reg}),
    .diff   (diff),
    .borrow (borrow)
  );

  // When there is no borrow, the difference is below the divisor and its MSB is 0.
  // Testing the MSB as well keeps the whole subtractor output in use.
  assign sub_ok = ~borrow & ~diff[WIDTH];
  assign r_next = sub_ok ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
  assign q_next = {q_reg[WIDTH-2:0], sub_ok};

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  // FSM, iteration counter, shift registers and result registers.
  // NOTE: every register here uses non-blocking assignment. All of them then
  // update from the same pre-edge values, and there is no ordering race.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      r_reg       <= '0;
      q_reg       <= '0;
      div_reg     <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (divisor != '0) begin
              div_reg <= divisor;
              q_reg   <= dividend;
              r_reg   <= '0;
              cnt     <= '0;
              state   <= ST_CALC;
            end else begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              state       <= ST_DONE;
            end
          end
        end
        ST_CALC: begin
          r_reg <= r_next;
          q_reg <= q_next;
          if (cnt == CNT_LAST) begin
            quotient    <= q_next;
            remainder   <= r_next;
            div_by_zero <= 1'b0;
            state       <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider16.sv
// Self-checking bench for seq_divider16: directed table, multi-cycle corner
// sequences and random operands checked against plain-arithmetic expectations.
module tb_seq_divider16;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_divider16 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  typedef struct {
    logic [W-1:0] n;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Waits at falling edges for done, for at most 'bound' rising edges.
  // It returns the number of rising edges taken, or -1 on timeout.
  task automatic wait_done(input int bound, output int edges);
    edges = 0;
    while (!done && edges < bound) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    if (!done) begin
      check("done_timeout", 32'd0, 32'd1);
      edges = -1;
    end
  endtask

  // Called at a falling edge in IDLE. It runs one division and returns at the
  // falling edge of the first IDLE cycle after DONE, so that a following call
  // is a back-to-back start.
  task automatic run_div(input logic [W-1:0] n, input logic [W-1:0] d,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic z, output int lat);
    int edges;
    start    = 1'b1;
    dividend = n;
    divisor  = d;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    wait_done(40, edges);
    lat = (edges < 0) ? -1 : edges;
    q   = quotient;
    r   = remainder;
    z   = div_by_zero;
    check("busy_with_done", 32'(busy), 32'd1);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("busy_drops", 32'(busy), 32'd0);
  endtask

  // Behavioural reference, derived from the division definition.
  function automatic void ref_div(input logic [W-1:0] n, input logic [W-1:0] d,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z);
    if (d == 0) begin
      q = {W{1'b1}}; r = n; z = 1'b1;
    end else begin
      q = W'(int'(n) / int'(d)); r = W'(int'(n) % int'(d)); z = 1'b0;
    end
  endfunction

  initial begin
    vec_t         vecs[9];
    logic [W-1:0] q, r, eq, er;
    logic         z, ez;
    int           lat, edges;
    bit           saw_done;

    vecs[0] = '{16'd100,   16'd7,      16'd14,     16'd2,  1'b0, 16};
    vecs[1] = '{16'hFFFF,  16'd1,      16'hFFFF,   16'd0,  1'b0, 16};
    vecs[2] = '{16'hFFFF,  16'hFFFF,   16'd1,      16'd0,  1'b0, 16};
    vecs[3] = '{16'd3,     16'd10,     16'd0,      16'd3,  1'b0, 16};
    vecs[4] = '{16'd5,     16'd0,      16'hFFFF,   16'd5,  1'b1, 0};
    vecs[5] = '{16'd0,     16'd5,      16'd0,      16'd0,  1'b0, 16};
    vecs[6] = '{16'd1234,  16'd1234,   16'd1,      16'd0,  1'b0, 16};
    vecs[7] = '{16'h8000,  16'd3,      16'd10922,  16'd2,  1'b0, 16};
    vecs[8] = '{16'd0,     16'd0,      16'hFFFF,   16'd0,  1'b1, 0};

    // Reset state.
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table. The runs are back to back.
    for (int i = 0; i < 9; i++) begin
      run_div(vecs[i].n, vecs[i].d, q, r, z, lat);
      check($sformatf("vec%0d_quotient", i), 32'(q), 32'(vecs[i].q));
      check($sformatf("vec%0d_remainder", i), 32'(r), 32'(vecs[i].r));
      check($sformatf("vec%0d_dbz", i), 32'(z), 32'(vecs[i].z));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
    end

    // Results are held while idle.
    repeat (5) @(negedge clk);
    check("hold_quotient", 32'(quotient), 32'hFFFF);
    check("hold_dbz", 32'(div_by_zero), 32'd1);

    // A start pulse during CALC is ignored.
    start = 1'b1; dividend = 16'd1000; divisor = 16'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; dividend = 16'd9; divisor = 16'd2;
    @(negedge clk);
    start = 1'b0;
    wait_done(40, edges);
    check("ignored_quotient", 32'(quotient), 32'd333);
    check("ignored_remainder", 32'(remainder), 32'd1);
    check("ignored_latency", 32'(edges + 5), 32'd16);
    @(negedge clk);
    check("ignored_no_requeue", 32'(busy), 32'd0);

    // Reset during CALC aborts the division, and no done pulse follows.
    start = 1'b1; dividend = 16'd1000; divisor = 16'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_quotient", 32'(quotient), 32'd0);
    check("abort_remainder", 32'(remainder), 32'd0);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    check("abort_no_done", 32'(saw_done), 32'd0);
    run_div(16'd50, 16'd5, q, r, z, lat);
    check("post_abort_quotient", 32'(q), 32'd10);
    check("post_abort_remainder", 32'(r), 32'd0);

    // Random operands against the reference and the division invariants.
    for (int i = 0; i < 2000; i++) begin
      logic [W-1:0] n, d;
      n = W'($urandom);
      d = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
      run_div(n, d, q, r, z, lat);
      ref_div(n, d, eq, er, ez);
      check("rand_quotient", 32'(q), 32'(eq));
      check("rand_remainder", 32'(r), 32'(er));
      check("rand_dbz", 32'(z), 32'(ez));
      if (d != 0) begin
        check("rand_invariant", 32'(int'(q) * int'(d) + int'(r)), 32'(n));
        check("rand_r_lt_d", 32'(r < d), 32'd1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
